ifu_nway: RTL and testbench
===========================

# ifu_nway

Parametrised N-wide instruction fetch unit. It sits between the branch predictor, the instruction MMU and the instruction buffer (ibuf). It keeps up to MAX_OUTSTANDING fetch requests in flight and delivers up to FETCH_WIDTH instructions per bundle, in order. Redirects are handled with a drop counter rather than a single cancel bit. After emitting a fetch exception, it halts until the next redirect.

## Interface
Parameters:
- FETCH_WIDTH, default 2: instructions per request; legal values 1, 2, 4.
- MAX_OUTSTANDING, default 2: maximum number of in-flight MMU requests; legal values 1–8.
- RESET_PC, default 32'h1c000000: fetch PC after reset.

Ports (CW = $clog2(FETCH_WIDTH+1); SW = $clog2(FETCH_WIDTH), min 1):
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, sampled on the rising edge
- ibuf_free  in  4  bundles ibuf can still accept (saturating)
- out_valid  out  1  bundle valid this cycle
- out_count  out  CW  valid instructions in bundle, 1..FETCH_WIDTH
- out_pc  out  32  PC of slot 0; slot i is at out_pc+4i
- out_insts  out  32*FETCH_WIDTH  slot i at bits [32i+31:32i]
- out_pred_taken  out  1  predicted-taken branch at slot out_count-1
- out_pred_target  out  32  predicted target
- out_excp  out  1  bundle carries a fetch exception
- out_excp_type  out  excp_t  ADEF/TLBR/PIF/PPI
- redirect_valid  in  1  flush from branch ctrl or CSR (pre-merged)
- redirect_target  in  32  new fetch PC
- pred_pc  out  32  current fetch PC, fed to the predictor
- pred_taken  in  1  taken prediction within the fetch group (combinational)
- pred_slot  in  SW  slot of the first predicted-taken branch
- pred_target  in  32  predicted target
- mmu_i_req  out  1  request valid
- mmu_i_addr  out  32  request address = fetch PC
- mmu_i_addr_ok  in  1  request accepted
- mmu_i_count  in  CW  words granted, 1..FETCH_WIDTH (valid with addr_ok)
- mmu_i_data_ok  in  1  in-order response
- mmu_i_rdata  in  32*FETCH_WIDTH  response words
- mmu_i_excp  in  1  response carries an exception (with data_ok)
- mmu_i_excp_type  in  excp_t  exception kind

## Operation
- State:
  - fetch_pc
  - metadata queue, MAX_OUTSTANDING entries: pc, eff_count, pred_taken, pred_target
  - outstanding counter
  - drop counter
  - halted flag
  - pending_adef flag
- Issue: mmu_i_req = !reset && !halted && !pending_adef && fetch_pc[1:0]==0 && outstanding<MAX_OUTSTANDING && ibuf_free > (outstanding − drop).
- On req && addr_ok, the accepted request is handled as follows:
  - g = mmu_i_count.
  - If pred_taken && pred_slot<g: eff_count = pred_slot+1 and fetch_pc ← pred_target. Otherwise eff_count = g and fetch_pc ← fetch_pc+4g.
  - Push one metadata entry; outstanding+1.
- Response (data_ok):
  - Pop the queue head; outstanding−1.
  - If drop>0: drop−1 and out_valid=0.
  - Otherwise, out_valid=1 and fields come from the head entry plus rdata.
  - With mmu_i_excp: out_count=1, slot 0 = NOP 32'h03400000, out_excp=1, halted ← 1.
- ADEF: when fetch_pc[1:0]≠0 and not halted, no request is issued and pending_adef ← 1.
  - Once outstanding==0 and ibuf_free>0, emit out_valid=1, out_count=1, out_pc=fetch_pc, slot 0 = NOP, out_excp=1, type ADEF.
  - Then halted ← 1 and pending_adef ← 0.
- Redirect (highest priority):
  - fetch_pc ← redirect_target; halted ← 0; pending_adef ← 0.
  - drop ← outstanding_next − 0, i.e. every request in flight after this edge, including one accepted this cycle, is dropped.
  - A response arriving in the redirect cycle is consumed and suppressed: out_valid forced 0.
- Outstanding and drop never exceed MAX_OUTSTANDING. drop ≤ outstanding always.
- Queue pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Reset values:
  - fetch_pc=RESET_PC; outstanding=0; drop=0; halted=0; pending_adef=0.
  - mmu_i_req=0 and out_valid=0 during the reset cycle.
  - The MMU is reset in the same cycle, so no stale responses arrive afterwards.
- mmu_i_req, mmu_i_addr and pred_pc are combinational from registered state; the predictor answers in the same cycle.
- out_* is combinational from the data_ok cycle, so there are zero cycles from response to bundle. Minimum request-to-bundle latency is 1 cycle.
- Simultaneous addr_ok and data_ok: outstanding is unchanged and the queue pushes and pops in the same cycle, which is legal even when full.
- Throughput: one bundle per cycle sustained when MMU latency ≤ MAX_OUTSTANDING.
- ibuf_free is sampled only for issue. The ibuf must accept every emitted bundle; it has no ready signal.

## Test plan
- Sequential fetch, FETCH_WIDTH=2, MMU latency 1, count=2 → bundles at PCs 1c000000, 1c000008, 1c000010…, out_count=2, one per cycle.
- Partial grant count=1 at 1c00000c → out_count=1; next request at 1c000010.
- pred_taken at slot 0 of 1c000000, target 1c000100 → out_count=1, out_pred_taken=1; next mmu_i_addr=1c000100.
- Two requests in flight, redirect to 1c000200 → next two data_ok produce out_valid=0; the first emitted bundle has out_pc=1c000200.
- Redirect to 1c000202 → no mmu_i_req. After drain: one bundle with out_excp=1, ADEF, inst NOP. Then idle until a redirect to 1c000300 resumes fetch.
- Response with mmu_i_excp=1 (TLBR) → out_excp=1, out_count=1, later responses dropped, no further requests until redirect. Reset asserted mid-flight → next mmu_i_addr=1c000000, counters 0.

Source files
------------

// File: rtl/ifu_nway.sv
// N-wide instruction fetch unit: issues in-order MMU requests, tracks their metadata,
// and turns responses into instruction bundles, with drop-counted redirects and fetch exceptions.
package ifu_nway_pkg;
    typedef enum logic [1:0] {
        EXCP_ADEF = 2'd0,
        EXCP_TLBR = 2'd1,
        EXCP_PIF  = 2'd2,
        EXCP_PPI  = 2'd3
    } excp_t;
endpackage

module ifu_nway
    import ifu_nway_pkg::*;
#(
    parameter int          FETCH_WIDTH     = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    localparam int         CW              = $clog2(FETCH_WIDTH + 1),
    localparam int         SW              = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               ibuf_free,
    output logic                     out_valid,
    output logic [CW-1:0]            out_count,
    output logic [31:0]              out_pc,
    output logic [32*FETCH_WIDTH-1:0] out_insts,
    output logic                     out_pred_taken,
    output logic [31:0]              out_pred_target,
    output logic                     out_excp,
    output excp_t                    out_excp_type,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_target,
    output logic [31:0]              pred_pc,
    input  logic                     pred_taken,
    input  logic [SW-1:0]            pred_slot,
    input  logic [31:0]              pred_target,
    output logic                     mmu_i_req,
    output logic [31:0]              mmu_i_addr,
    input  logic                     mmu_i_addr_ok,
    input  logic [CW-1:0]            mmu_i_count,
    input  logic                     mmu_i_data_ok,
    input  logic [32*FETCH_WIDTH-1:0] mmu_i_rdata,
    input  logic                     mmu_i_excp,
    input  excp_t                    mmu_i_excp_type
);
    localparam int          OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int          PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] NOP = 32'h03400000;

    logic [31:0]   r_fetch_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop;
    logic          r_halted;
    logic          r_pending_adef;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;

    logic [31:0]   r_q_pc     [MAX_OUTSTANDING];
    logic [CW-1:0] r_q_cnt    [MAX_OUTSTANDING];
    logic          r_q_taken  [MAX_OUTSTANDING];
    logic [31:0]   r_q_target [MAX_OUTSTANDING];

    logic          w_aligned;
    logic [3:0]    w_live;
    logic          w_req;
    logic          w_acc;
    logic [CW-1:0] w_slot;
    logic          w_taken;
    logic [CW-1:0] w_eff;
    logic [31:0]   w_seq_pc;
    logic          w_resp_emit;
    logic          w_adef_emit;
    logic [OW-1:0] w_out_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1))
            return '0;
        return p + PW'(1);
    endfunction

    // Requests already being dropped do not occupy ibuf space when sampling ibuf_free.
    assign w_aligned   = (r_fetch_pc[1:0] == 2'b00);
    assign w_live      = 4'(r_outstanding - r_drop);
    assign w_req       = !reset && !r_halted && !r_pending_adef && w_aligned &&
                         (r_outstanding < OW'(MAX_OUTSTANDING)) && (ibuf_free > w_live);
    assign w_acc       = w_req && mmu_i_addr_ok;
    assign w_slot      = CW'(pred_slot);
    assign w_taken     = pred_taken && (w_slot < mmu_i_count);
    assign w_eff       = w_taken ? (w_slot + CW'(1)) : mmu_i_count;
    assign w_seq_pc    = r_fetch_pc + (32'(mmu_i_count) << 2);
    assign w_out_next  = r_outstanding + OW'(w_acc) - OW'(mmu_i_data_ok);
    assign w_resp_emit = !reset && mmu_i_data_ok && (r_drop == '0) && !r_halted && !redirect_valid;
    assign w_adef_emit = !reset && r_pending_adef && !r_halted && (r_outstanding == '0) &&
                         (ibuf_free != 4'd0) && !redirect_valid;

    assign mmu_i_req  = w_req;
    assign mmu_i_addr = r_fetch_pc;
    assign pred_pc    = r_fetch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc     <= RESET_PC;
            r_outstanding  <= '0;
            r_drop         <= '0;
            r_halted       <= 1'b0;
            r_pending_adef <= 1'b0;
            r_wptr         <= '0;
            r_rptr         <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_acc)
                r_wptr <= ptr_inc(r_wptr);
            if (mmu_i_data_ok)
                r_rptr <= ptr_inc(r_rptr);

            if (redirect_valid)
                r_fetch_pc <= redirect_target;
            else if (w_acc)
                r_fetch_pc <= w_taken ? pred_target : w_seq_pc;

            // Everything still in flight after a redirect edge belongs to the old path.
            if (redirect_valid)
                r_drop <= w_out_next;
            else if (mmu_i_data_ok && (r_drop != '0))
                r_drop <= r_drop - OW'(1);

            if (redirect_valid) begin
                r_halted       <= 1'b0;
                r_pending_adef <= 1'b0;
            end else if (w_adef_emit || (w_resp_emit && mmu_i_excp)) begin
                r_halted       <= 1'b1;
                r_pending_adef <= 1'b0;
            end else if (!r_halted && !w_aligned) begin
                r_pending_adef <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_q_pc[r_wptr]     <= r_fetch_pc;
            r_q_cnt[r_wptr]    <= w_eff;
            r_q_taken[r_wptr]  <= w_taken;
            r_q_target[r_wptr] <= pred_target;
        end
    end

    always_comb begin
        out_valid       = w_resp_emit || w_adef_emit;
        out_count       = r_q_cnt[r_rptr];
        out_pc          = r_q_pc[r_rptr];
        out_insts       = mmu_i_rdata;
        out_pred_taken  = r_q_taken[r_rptr];
        out_pred_target = r_q_target[r_rptr];
        out_excp        = 1'b0;
        out_excp_type   = mmu_i_excp_type;
        if (w_adef_emit) begin
            out_count       = CW'(1);
            out_pc          = r_fetch_pc;
            out_insts       = '0;
            out_insts[31:0] = NOP;
            out_pred_taken  = 1'b0;
            out_excp        = 1'b1;
            out_excp_type   = EXCP_ADEF;
        end else if (mmu_i_excp) begin
            out_count       = CW'(1);
            out_insts       = '0;
            out_insts[31:0] = NOP;
            out_pred_taken  = 1'b0;
            out_excp        = 1'b1;
        end
    end
endmodule

// File: tb/tb_ifu_nway.sv
// Randomised bench for ifu_nway: an in-bench MMU and fetch model predict every request and
// bundle; a negedge monitor pops expected bundles from a scoreboard queue and compares.
module tb_ifu_nway;
    import ifu_nway_pkg::*;

    localparam int          FW     = 2;
    localparam int          MO     = 2;
    localparam int          CW     = $clog2(FW + 1);
    localparam int          SW     = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam logic [31:0] NOP    = 32'h03400000;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        ibuf_free;
    logic              out_valid;
    logic [CW-1:0]     out_count;
    logic [31:0]       out_pc;
    logic [32*FW-1:0]  out_insts;
    logic              out_pred_taken;
    logic [31:0]       out_pred_target;
    logic              out_excp;
    excp_t             out_excp_type;
    logic              redirect_valid;
    logic [31:0]       redirect_target;
    logic [31:0]       pred_pc;
    logic              pred_taken;
    logic [SW-1:0]     pred_slot;
    logic [31:0]       pred_target;
    logic              mmu_i_req;
    logic [31:0]       mmu_i_addr;
    logic              mmu_i_addr_ok;
    logic [CW-1:0]     mmu_i_count;
    logic              mmu_i_data_ok;
    logic [32*FW-1:0]  mmu_i_rdata;
    logic              mmu_i_excp;
    excp_t             mmu_i_excp_type;

    ifu_nway #(.FETCH_WIDTH(FW), .MAX_OUTSTANDING(MO), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .ibuf_free(ibuf_free),
        .out_valid(out_valid), .out_count(out_count), .out_pc(out_pc), .out_insts(out_insts),
        .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
        .out_excp(out_excp), .out_excp_type(out_excp_type),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
        .mmu_i_req(mmu_i_req), .mmu_i_addr(mmu_i_addr), .mmu_i_addr_ok(mmu_i_addr_ok),
        .mmu_i_count(mmu_i_count), .mmu_i_data_ok(mmu_i_data_ok), .mmu_i_rdata(mmu_i_rdata),
        .mmu_i_excp(mmu_i_excp), .mmu_i_excp_type(mmu_i_excp_type)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int cnt; bit pt; logic [31:0] tgt; bit dropped; } infl_t;
    typedef struct { logic [31:0] pc; int ready; } mreq_t;
    typedef struct {
        logic [31:0] pc; int cnt; logic [32*FW-1:0] insts;
        bit pt; logic [31:0] tgt; bit excp; excp_t etype;
    } bnd_t;

    infl_t m_q[$];
    mreq_t mmu_q[$];
    bnd_t  exp_q[$];

    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_pending;
    int          last_ready;
    int          gcyc;
    int          n_chk;
    int          n_pass;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, a[31:16] ^ a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: actual %h required %h at %0t", nm, act, req, $time);
    endtask

    // Bundle monitor: every presented bundle must be the oldest expected one.
    always @(negedge clk) begin
        bnd_t b;
        if (reset !== 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_bundle: actual out_valid=1 out_pc=%h required out_valid=0 at %0t",
                         out_pc, $time);
            end else begin
                b = exp_q.pop_front();
                check("out_pc", out_pc, b.pc);
                check("out_count", out_count, b.cnt);
                check("out_excp", out_excp, b.excp);
                for (int i = 0; i < b.cnt; i++)
                    check("out_inst", out_insts[32*i +: 32], b.insts[32*i +: 32]);
                if (b.excp)
                    check("out_excp_type", out_excp_type, b.etype);
                else begin
                    check("out_pred_taken", out_pred_taken, b.pt);
                    if (b.pt)
                        check("out_pred_target", out_pred_target, b.tgt);
                end
            end
        end
    end

    task automatic model_reset();
        m_q.delete();
        mmu_q.delete();
        m_pc       = RST_PC;
        m_halted   = 0;
        m_pending  = 0;
        last_ready = 0;
    endtask

    // phase 0: sequential fetch, latency 1; 1: random; 2: drain; 3: one reset cycle
    task automatic cycle(input int phase);
        logic [31:0] old_pc, npc;
        bit          old_halted, old_pending, exp_req, acc, taken, excp_emit, adef_emit;
        int          old_size, ndrop, eff, lat, rdy;
        infl_t       h;
        bnd_t        nb;
        mreq_t       mr;
        @(posedge clk);
        #1;
        gcyc++;
        if (phase == 3) begin
            reset = 1; redirect_valid = 0; mmu_i_addr_ok = 0; mmu_i_data_ok = 0;
            mmu_i_excp = 0; ibuf_free = 4'd4;
            #1;
            check("reset_req", mmu_i_req, 0);
            check("reset_valid", out_valid, 0);
            model_reset();
            return;
        end
        reset           = 0;
        ibuf_free       = (phase == 0) ? 4'd15 : 4'($urandom_range(0, 4));
        redirect_valid  = (phase == 1) && ($urandom_range(0, 11) == 0);
        redirect_target = {20'h1c000, 10'($urandom_range(0, 1023)),
                           ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00};
        mmu_i_data_ok   = (mmu_q.size() > 0) && (mmu_q[0].ready <= gcyc) &&
                          ((phase == 0) || ($urandom_range(0, 3) != 0));
        mmu_i_rdata     = '0;
        mmu_i_excp      = 0;
        mmu_i_excp_type = excp_t'(2'($urandom_range(1, 3)));
        if (mmu_i_data_ok) begin
            for (int i = 0; i < FW; i++)
                mmu_i_rdata[32*i +: 32] = mem_word(mmu_q[0].pc + 32'(4 * i));
            mmu_i_excp = (phase == 1) && ($urandom_range(0, 15) == 0);
        end
        mmu_i_addr_ok = (phase == 0) || ((phase == 1) && ($urandom_range(0, 3) != 0));
        mmu_i_count   = (phase == 0) ? CW'(FW) : CW'($urandom_range(1, FW));
        pred_taken    = (phase == 1) && ($urandom_range(0, 4) == 0);
        pred_slot     = SW'($urandom_range(0, FW - 1));
        pred_target   = {20'h1c001, 10'($urandom_range(0, 1023)),
                         ($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00};
        #1;

        old_pc = m_pc; old_halted = m_halted; old_pending = m_pending; old_size = m_q.size();
        ndrop = 0;
        foreach (m_q[i]) if (m_q[i].dropped) ndrop++;
        exp_req = !m_halted && !m_pending && (m_pc[1:0] == 2'b00) && (old_size < MO) &&
                  (int'(ibuf_free) > old_size - ndrop);
        check("mmu_i_req", mmu_i_req, exp_req);
        if (exp_req)
            check("mmu_i_addr", mmu_i_addr, m_pc);
        check("pred_pc", pred_pc, m_pc);
        acc = exp_req && mmu_i_addr_ok;

        excp_emit = 0;
        if (mmu_i_data_ok) begin
            h  = m_q.pop_front();
            mr = mmu_q.pop_front();
            if (!h.dropped && !old_halted && !redirect_valid) begin
                nb.pc = h.pc; nb.insts = '0; nb.pt = h.pt; nb.tgt = h.tgt;
                nb.excp = mmu_i_excp; nb.etype = mmu_i_excp_type;
                if (mmu_i_excp) begin
                    nb.cnt = 1;
                    nb.insts[31:0] = NOP;
                end else begin
                    nb.cnt = h.cnt;
                    for (int i = 0; i < h.cnt; i++)
                        nb.insts[32*i +: 32] = mem_word(h.pc + 32'(4 * i));
                end
                exp_q.push_back(nb);
                excp_emit = mmu_i_excp;
            end
        end

        adef_emit = old_pending && !old_halted && (old_size == 0) && (ibuf_free != 0) && !redirect_valid;
        if (adef_emit) begin
            nb.pc = old_pc; nb.cnt = 1; nb.insts = '0; nb.insts[31:0] = NOP;
            nb.pt = 0; nb.tgt = '0; nb.excp = 1; nb.etype = EXCP_ADEF;
            exp_q.push_back(nb);
        end

        npc = m_pc;
        if (acc) begin
            taken = pred_taken && (int'(pred_slot) < int'(mmu_i_count));
            eff   = taken ? int'(pred_slot) + 1 : int'(mmu_i_count);
            npc   = taken ? pred_target : m_pc + 32'(4 * int'(mmu_i_count));
            m_q.push_back('{pc: m_pc, cnt: eff, pt: taken, tgt: pred_target, dropped: 0});
            lat = (phase == 0) ? 1 : $urandom_range(1, 3);
            rdy = (gcyc + lat > last_ready) ? gcyc + lat : last_ready;
            last_ready = rdy;
            mmu_q.push_back('{pc: m_pc, ready: rdy});
        end

        if (redirect_valid) begin
            foreach (m_q[i]) m_q[i].dropped = 1;
            m_pc = redirect_target; m_halted = 0; m_pending = 0;
        end else begin
            m_pc = npc;
            if (adef_emit || excp_emit) begin
                m_halted = 1; m_pending = 0;
            end else if (!old_halted && old_pc[1:0] != 2'b00) begin
                m_pending = 1;
            end
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0; gcyc = 0;
        reset = 1; ibuf_free = 4'd0; redirect_valid = 0; redirect_target = '0;
        pred_taken = 0; pred_slot = '0; pred_target = '0;
        mmu_i_addr_ok = 0; mmu_i_count = CW'(1); mmu_i_data_ok = 0; mmu_i_rdata = '0;
        mmu_i_excp = 0; mmu_i_excp_type = EXCP_TLBR;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", mmu_i_req, 0);
        check("reset_valid", out_valid, 0);
        reset = 0;
        repeat (30) cycle(0);
        repeat (1500) cycle(1);
        cycle(3);
        repeat (1500) cycle(1);
        repeat (30) cycle(2);
        @(posedge clk);
        #1;
        check("unreturned_bundles", exp_q.size(), 0);
        check("mmu_drained", mmu_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
